r5p_bus_arb: RTL and testbench
==============================

Name: r5p_bus_arb

Overview:
- Shares one memory port between the core's instruction-fetch bus and its load/store bus, for single-port SRAM or single-master interconnect builds.
- Arbitrates requests and locks the grant across a stalled transfer.
- Routes read data back to the requester whose read was accepted, one cycle after the handshake.
- Holds each requester's last read data stable while the core stalls.

Parameters:
- AW, 32, address width (IF and LS share it).
- DW, 32, data width (must match core XLEN and IDW).
- BW, DW/8, byte enable width.
- RR, 1'b0, 0 = fixed priority (LS over IF); 1 = round-robin between IF and LS.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active high
- if_vld  input  1  fetch request
- if_adr  input  AW  fetch address
- if_rdt  output  DW  fetch read data
- if_rdy  output  1  fetch accepted
- ls_vld  input  1  load/store request
- ls_wen  input  1  write enable
- ls_adr  input  AW  address
- ls_ben  input  BW  byte enable
- ls_wdt  input  DW  write data
- ls_rdt  output  DW  load read data
- ls_rdy  output  1  load/store accepted
- m_vld  output  1  shared bus request
- m_wen  output  1  shared bus write enable
- m_adr  output  AW  shared bus address
- m_ben  output  BW  shared bus byte enable
- m_wdt  output  DW  shared bus write data
- m_rdt  input  DW  shared bus read data (valid the cycle after a read handshake)
- m_rdy  input  1  shared bus accept

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst).
- Handshake on every bus: a transfer completes when vld & rdy are both high. Requesters hold vld and payload stable until rdy.
- State registers:
  - lck/lck_own: grant locked, with owner, while m_vld & ~m_rdy.
  - rsp_own: response owner, enum {NONE, IF, LS}.
  - lst: last-served requester, for RR.
  - if_hld, ls_hld: DW read-data holders.
- Reset values: lck=0, rsp_own=NONE, lst=LS (so IF wins the first RR tie), if_hld=ls_hld=0.
- Reset-time outputs: if_rdt=ls_rdt=0; m_vld=0 and if_rdy=ls_rdy=0 while if_vld=ls_vld=0.
- Grant, combinational, zero-cycle latency:
  - If lck, grant = lck_own.
  - Else if only one requester is valid, grant that one.
  - Else if both are valid: RR=0 grants LS; RR=1 grants the requester that is not lst.
- Lock:
  - Set on m_vld & ~m_rdy, with lck_own = grant.
  - Cleared on m_vld & m_rdy.
  - No grant switch mid-transfer, even if the higher-priority requester asserts vld.
- Muxing:
  - m_vld = granted requester's vld.
  - IF grant drives m_wen=0, m_ben='1, m_wdt='0, m_adr=if_adr.
  - LS grant forwards the ls_* signals.
  - No requester valid gives m_vld=0; other outputs are don't-care but must be driven to 0.
- Ready: if_rdy = grant==IF & m_rdy; ls_rdy = grant==LS & m_rdy. The non-granted requester sees rdy=0.
- lst updates to the granted requester on every handshake.
- Response routing:
  - On a handshake with m_wen=0, rsp_own <= grant. Otherwise, on the next clock, rsp_own <= NONE.
  - Writes produce no response cycle.
  - In the cycle rsp_own==IF: if_rdt = m_rdt and if_hld <= m_rdt. Otherwise if_rdt = if_hld. LS is symmetric.
  - Back-to-back reads with zero bubbles are supported: throughput is 1 transfer/cycle, and rsp_own updates every cycle.
- Boundary cases:
  - Simultaneous IF and LS requests with m_rdy=1 every cycle and RR=1: strict alternation.
  - Simultaneous requests with RR=0: IF is starved while ls_vld stays high. This is intended, because the core stalls on LS.
  - A requester dropping vld while locked is a protocol violation. The lock still holds; an assertion flags it.
  - Reset mid-transfer: lck and rsp_own clear immediately (async), holders clear to 0, and the pending response is discarded.
- Assertions (sim only):
  - Requester vld/payload stable while vld & ~rdy.
  - if_rdy & ls_rdy never both high.

Decomposition:
- r5p_pkg gains the typedef enum logic [1:0] {ARB_NONE, ARB_IF, ARB_LS} arb_own_t, shared by the arbiter and the response logic.
- Sub-module r5p_bus_rsp (params DW; ports clk, rst, sel, m_rdt, rdt) implements one response-hold register plus its bypass mux, instantiated once per requester.
- Arbitration and lock stay in r5p_bus_arb.

Test Plan:
- IF-only reads with m_rdy=1 at if_adr 0x0, 0x4, 0x8 and m_rdt 0x11, 0x22, 0x33 -> if_rdy=1 each cycle; if_rdt is 0x11/0x22/0x33 one cycle after each handshake; ls_rdt stays 0.
- Both valid, RR=0, m_rdy=1, 3 cycles -> LS granted all 3 cycles; if_rdy=0; m_adr=ls_adr.
- Both valid, RR=1, m_rdy=1 -> grants IF, LS, IF, LS; if_rdt/ls_rdt receive their own m_rdt values (0xA0, 0xB0, ...).
- IF granted with m_rdy=0 for 3 cycles, ls_vld rising in cycle 2, RR=0 -> grant stays IF until m_rdy=1; LS is granted the following cycle.
- LS write (ls_wen=1, ben=4'b0011, wdt=0xDEADBEEF) followed by an IF read -> m_* match the write, rsp_own stays NONE, ls_rdt is unchanged, and the IF read data routes correctly.
- Stall hold: IF read returns 0x1234; m_rdt then changes to 0xFFFF and no new IF handshake occurs for 4 cycles -> if_rdt stays 0x1234. Asserting rst mid-lock -> all rdy=0 and rdt=0 immediately.

Source files
------------

// File: rtl/r5p_pkg.sv
// rtl/r5p_pkg.sv - shared types for the r5p bus arbiter
package r5p_pkg;

    typedef enum logic [1:0] {
        ARB_NONE = 2'd0,
        ARB_IF   = 2'd1,
        ARB_LS   = 2'd2
    } arb_own_t;

endpackage

// File: rtl/r5p_bus_rsp.sv
// rtl/r5p_bus_rsp.sv - per-requester read-data holder with same-cycle bypass
module r5p_bus_rsp #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sel,
    input  logic [DW-1:0] m_rdt,
    output logic [DW-1:0] rdt
);

    logic [DW-1:0] r_hld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hld <= '0;
        end else if (sel) begin
            r_hld <= m_rdt;
        end
    end

    // Bypass in the response cycle so data reaches the requester without an extra stage
    assign rdt = sel ? m_rdt : r_hld;

endmodule

// File: rtl/r5p_bus_arb.sv
// rtl/r5p_bus_arb.sv - IF/LS arbiter sharing one memory port, grant locked across stalls
module r5p_bus_arb
    import r5p_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int BW = DW/8,
    parameter bit RR = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_vld,
    input  logic [AW-1:0] if_adr,
    output logic [DW-1:0] if_rdt,
    output logic          if_rdy,
    input  logic          ls_vld,
    input  logic          ls_wen,
    input  logic [AW-1:0] ls_adr,
    input  logic [BW-1:0] ls_ben,
    input  logic [DW-1:0] ls_wdt,
    output logic [DW-1:0] ls_rdt,
    output logic          ls_rdy,
    output logic          m_vld,
    output logic          m_wen,
    output logic [AW-1:0] m_adr,
    output logic [BW-1:0] m_ben,
    output logic [DW-1:0] m_wdt,
    input  logic [DW-1:0] m_rdt,
    input  logic          m_rdy
);

    logic     r_lck;
    arb_own_t r_lck_own;
    arb_own_t r_rsp_own;
    arb_own_t r_lst;
    arb_own_t w_grant;
    logic     w_hs;

    always_comb begin
        w_grant = ARB_NONE;
        if (r_lck) begin
            w_grant = r_lck_own;
        end else if (if_vld && ls_vld) begin
            // Round-robin hands the tie to whoever was not served last
            w_grant = (RR && (r_lst == ARB_LS)) ? ARB_IF : ARB_LS;
        end else if (if_vld) begin
            w_grant = ARB_IF;
        end else if (ls_vld) begin
            w_grant = ARB_LS;
        end
    end

    always_comb begin
        m_vld = 1'b0;
        m_wen = 1'b0;
        m_adr = '0;
        m_ben = '0;
        m_wdt = '0;
        case (w_grant)
            ARB_IF: begin
                m_vld = if_vld;
                m_adr = if_adr;
                m_ben = '1;
            end
            ARB_LS: begin
                m_vld = ls_vld;
                m_wen = ls_wen;
                m_adr = ls_adr;
                m_ben = ls_ben;
                m_wdt = ls_wdt;
            end
            default: ;
        endcase
    end

    assign if_rdy = (w_grant == ARB_IF) && m_rdy;
    assign ls_rdy = (w_grant == ARB_LS) && m_rdy;
    assign w_hs   = m_vld && m_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lck     <= 1'b0;
            r_lck_own <= ARB_NONE;
            r_rsp_own <= ARB_NONE;
            r_lst     <= ARB_LS;
        end else begin
            if (m_vld && !m_rdy) begin
                r_lck     <= 1'b1;
                r_lck_own <= w_grant;
            end else if (w_hs) begin
                r_lck     <= 1'b0;
            end
            if (w_hs) begin
                r_lst <= w_grant;
            end
            // Writes never return data, so only read handshakes claim the next cycle
            r_rsp_own <= (w_hs && !m_wen) ? w_grant : ARB_NONE;
        end
    end

    r5p_bus_rsp #(.DW(DW)) u_if_rsp (
        .clk   (clk),
        .rst   (rst),
        .sel   (r_rsp_own == ARB_IF),
        .m_rdt (m_rdt),
        .rdt   (if_rdt)
    );

    r5p_bus_rsp #(.DW(DW)) u_ls_rsp (
        .clk   (clk),
        .rst   (rst),
        .sel   (r_rsp_own == ARB_LS),
        .m_rdt (m_rdt),
        .rdt   (ls_rdt)
    );

`ifndef SYNTHESIS
    a_if_stable: assert property (@(posedge clk) disable iff (rst)
        (if_vld && !if_rdy) |=> (if_vld && $stable(if_adr)));

    a_ls_stable: assert property (@(posedge clk) disable iff (rst)
        (ls_vld && !ls_rdy) |=> (ls_vld && $stable({ls_wen, ls_adr, ls_ben, ls_wdt})));

    a_rdy_excl: assert property (@(posedge clk) disable iff (rst)
        !(if_rdy && ls_rdy));
`endif

endmodule

// File: tb/tb_r5p_bus_arb.sv
// tb/tb_r5p_bus_arb.sv - bench for r5p_bus_arb, fixed-priority and round-robin instances
module tb_r5p_bus_arb;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          if_vld [2];
    logic [AW-1:0] if_adr [2];
    logic [DW-1:0] if_rdt [2];
    logic          if_rdy [2];
    logic          ls_vld [2];
    logic          ls_wen [2];
    logic [AW-1:0] ls_adr [2];
    logic [BW-1:0] ls_ben [2];
    logic [DW-1:0] ls_wdt [2];
    logic [DW-1:0] ls_rdt [2];
    logic          ls_rdy [2];
    logic          m_vld  [2];
    logic          m_wen  [2];
    logic [AW-1:0] m_adr  [2];
    logic [BW-1:0] m_ben  [2];
    logic [DW-1:0] m_wdt  [2];
    logic [DW-1:0] m_rdt  [2];
    logic          m_rdy  [2];

    r5p_bus_arb #(.AW(AW), .DW(DW), .BW(BW), .RR(1'b0)) u_fix (
        .clk(clk), .rst(rst),
        .if_vld(if_vld[0]), .if_adr(if_adr[0]), .if_rdt(if_rdt[0]), .if_rdy(if_rdy[0]),
        .ls_vld(ls_vld[0]), .ls_wen(ls_wen[0]), .ls_adr(ls_adr[0]), .ls_ben(ls_ben[0]),
        .ls_wdt(ls_wdt[0]), .ls_rdt(ls_rdt[0]), .ls_rdy(ls_rdy[0]),
        .m_vld(m_vld[0]), .m_wen(m_wen[0]), .m_adr(m_adr[0]), .m_ben(m_ben[0]),
        .m_wdt(m_wdt[0]), .m_rdt(m_rdt[0]), .m_rdy(m_rdy[0])
    );

    r5p_bus_arb #(.AW(AW), .DW(DW), .BW(BW), .RR(1'b1)) u_rr (
        .clk(clk), .rst(rst),
        .if_vld(if_vld[1]), .if_adr(if_adr[1]), .if_rdt(if_rdt[1]), .if_rdy(if_rdy[1]),
        .ls_vld(ls_vld[1]), .ls_wen(ls_wen[1]), .ls_adr(ls_adr[1]), .ls_ben(ls_ben[1]),
        .ls_wdt(ls_wdt[1]), .ls_rdt(ls_rdt[1]), .ls_rdy(ls_rdy[1]),
        .m_vld(m_vld[1]), .m_wen(m_wen[1]), .m_adr(m_adr[1]), .m_ben(m_ben[1]),
        .m_wdt(m_wdt[1]), .m_rdt(m_rdt[1]), .m_rdy(m_rdy[1])
    );

    // Model: 0 = nobody, 1 = IF, 2 = LS; instance 1 is round-robin
    int            md_lck [2];
    int            md_lst [2];
    int            md_rsp [2];
    logic [DW-1:0] md_ifh [2];
    logic [DW-1:0] md_lsh [2];
    int            s_g    [2];
    bit            s_hs   [2];
    bit            s_stl  [2];
    bit            s_wen  [2];
    logic [DW-1:0] s_mrdt [2];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d] t=%0t got %h expected %h", nm, k, $time, act, exp);
    endtask

    function automatic int exp_grant(input int k);
        if (md_lck[k] != 0) return md_lck[k];
        if (if_vld[k] && ls_vld[k]) return (k == 1) ? (3 - md_lst[k]) : 2;
        if (if_vld[k]) return 1;
        if (ls_vld[k]) return 2;
        return 0;
    endfunction

    task automatic mdl_reset();
        for (int k = 0; k < 2; k++) begin
            md_lck[k] = 0; md_lst[k] = 2; md_rsp[k] = 0;
            md_ifh[k] = '0; md_lsh[k] = '0;
        end
    endtask

    task automatic idle(input int k);
        if_vld[k] = 0; if_adr[k] = '0;
        ls_vld[k] = 0; ls_wen[k] = 0; ls_adr[k] = '0; ls_ben[k] = '0; ls_wdt[k] = '0;
        m_rdy[k] = 0; m_rdt[k] = '0;
    endtask

    task automatic sample();
        int            g;
        logic          e_vld, e_wen;
        logic [BW-1:0] e_ben;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_wdt;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            g = exp_grant(k);
            e_vld = 0; e_wen = 0; e_ben = '0; e_adr = '0; e_wdt = '0;
            if (g == 1) begin
                e_vld = if_vld[k]; e_adr = if_adr[k]; e_ben = '1;
            end else if (g == 2) begin
                e_vld = ls_vld[k]; e_wen = ls_wen[k]; e_adr = ls_adr[k];
                e_ben = ls_ben[k]; e_wdt = ls_wdt[k];
            end
            chk("m_ctl", k, {m_vld[k], m_wen[k], m_ben[k]}, {e_vld, e_wen, e_ben});
            chk("m_adr", k, m_adr[k], e_adr);
            chk("m_wdt", k, m_wdt[k], e_wdt);
            chk("if_rdy", k, if_rdy[k], (g == 1) && m_rdy[k]);
            chk("ls_rdy", k, ls_rdy[k], (g == 2) && m_rdy[k]);
            chk("if_rdt", k, if_rdt[k], (md_rsp[k] == 1) ? m_rdt[k] : md_ifh[k]);
            chk("ls_rdt", k, ls_rdt[k], (md_rsp[k] == 2) ? m_rdt[k] : md_lsh[k]);
            s_g[k]    = g;
            s_hs[k]   = e_vld && m_rdy[k];
            s_stl[k]  = e_vld && !m_rdy[k];
            s_wen[k]  = e_wen;
            s_mrdt[k] = m_rdt[k];
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            mdl_reset();
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (md_rsp[k] == 1) md_ifh[k] = s_mrdt[k];
                if (md_rsp[k] == 2) md_lsh[k] = s_mrdt[k];
                if (s_stl[k]) md_lck[k] = s_g[k];
                else if (s_hs[k]) md_lck[k] = 0;
                if (s_hs[k]) md_lst[k] = s_g[k];
                md_rsp[k] = (s_hs[k] && !s_wen[k]) ? s_g[k] : 0;
            end
        end
        #1;
    endtask

    initial begin
        logic [DW-1:0] t4_rdt [4];
        t4_rdt[0] = 32'h0; t4_rdt[1] = 32'hA0; t4_rdt[2] = 32'hB0; t4_rdt[3] = 32'hA1;

        rst = 1'b1;
        idle(0); idle(1);
        mdl_reset();
        sample();
        for (int k = 0; k < 2; k++) begin
            chk("rst_m_vld", k, m_vld[k], 0);
            chk("rst_rdy", k, {if_rdy[k], ls_rdy[k]}, 0);
            chk("rst_rdt", k, {if_rdt[k], ls_rdt[k]}, 0);
        end
        advance();
        rst = 1'b0;

        // IF-only reads on the fixed-priority instance
        if_vld[0] = 1; if_adr[0] = 32'h0; m_rdy[0] = 1; m_rdt[0] = 32'h0;
        sample(); chk("t2_if_rdy", 0, if_rdy[0], 1); advance();
        if_adr[0] = 32'h4; m_rdt[0] = 32'h11;
        sample(); chk("t2_if_rdy", 0, if_rdy[0], 1); chk("t2_if_rdt", 0, if_rdt[0], 32'h11); advance();
        if_adr[0] = 32'h8; m_rdt[0] = 32'h22;
        sample(); chk("t2_if_rdy", 0, if_rdy[0], 1); chk("t2_if_rdt", 0, if_rdt[0], 32'h22); advance();
        if_vld[0] = 0; m_rdt[0] = 32'h33;
        sample(); chk("t2_if_rdt", 0, if_rdt[0], 32'h33); chk("t2_ls_rdt", 0, ls_rdt[0], 0); advance();
        m_rdt[0] = 32'h0;
        sample(); chk("t2_if_hold", 0, if_rdt[0], 32'h33); advance();

        // Fixed priority: LS wins every tie
        if_vld[0] = 1; if_adr[0] = 32'h100; ls_vld[0] = 1; ls_ben[0] = 4'hF;
        for (int i = 0; i < 3; i++) begin
            ls_adr[0] = 32'h200 + 32'(i * 4);
            sample();
            chk("t3_ls_rdy", 0, ls_rdy[0], 1);
            chk("t3_if_rdy", 0, if_rdy[0], 0);
            chk("t3_m_adr", 0, m_adr[0], 32'h200 + 32'(i * 4));
            advance();
        end
        ls_vld[0] = 0;
        sample(); chk("t3_if_late", 0, if_rdy[0], 1); advance();
        if_vld[0] = 0;

        // Lock holds IF across a stall even after LS arrives
        if_vld[0] = 1; if_adr[0] = 32'h300; m_rdy[0] = 0;
        sample(); chk("t5_m_adr", 0, m_adr[0], 32'h300); chk("t5_if_rdy", 0, if_rdy[0], 0); advance();
        ls_vld[0] = 1; ls_adr[0] = 32'h400; ls_wen[0] = 0; ls_ben[0] = 4'hF;
        for (int i = 0; i < 2; i++) begin
            sample(); chk("t5_m_adr", 0, m_adr[0], 32'h300); chk("t5_ls_rdy", 0, ls_rdy[0], 0); advance();
        end
        m_rdy[0] = 1;
        sample(); chk("t5_if_rdy", 0, if_rdy[0], 1); chk("t5_ls_rdy", 0, ls_rdy[0], 0); advance();
        if_vld[0] = 0;
        sample(); chk("t5_ls_next", 0, ls_rdy[0], 1); chk("t5_m_adr", 0, m_adr[0], 32'h400); advance();
        ls_vld[0] = 0;

        // Read data held while the requester stalls
        if_vld[0] = 1; if_adr[0] = 32'h500; m_rdy[0] = 1;
        sample(); advance();
        if_vld[0] = 0; m_rdt[0] = 32'h1234;
        sample(); chk("t7_if_rdt", 0, if_rdt[0], 32'h1234); advance();
        m_rdt[0] = 32'hFFFF;
        for (int i = 0; i < 4; i++) begin
            sample(); chk("t7_hold", 0, if_rdt[0], 32'h1234); advance();
        end

        // Round-robin alternation on instance 1
        if_vld[1] = 1; if_adr[1] = 32'h600; ls_vld[1] = 1; ls_adr[1] = 32'h700;
        ls_wen[1] = 0; ls_ben[1] = 4'hF; m_rdy[1] = 1;
        for (int i = 0; i < 4; i++) begin
            m_rdt[1] = t4_rdt[i];
            sample();
            chk("t4_if_rdy", 1, if_rdy[1], (i % 2) == 0);
            chk("t4_ls_rdy", 1, ls_rdy[1], (i % 2) == 1);
            if (i == 2) begin
                chk("t4_ls_rdt", 1, ls_rdt[1], 32'hB0);
                chk("t4_if_rdt", 1, if_rdt[1], 32'hA0);
            end
            advance();
        end
        ls_vld[1] = 0; m_rdt[1] = 32'hB1;
        sample(); chk("t4_if_rdy", 1, if_rdy[1], 1); chk("t4_ls_rdt", 1, ls_rdt[1], 32'hB1);
        chk("t4_if_rdt", 1, if_rdt[1], 32'hA1); advance();
        if_vld[1] = 0; m_rdt[1] = 32'hA2;
        sample(); chk("t4_if_rdt", 1, if_rdt[1], 32'hA2); advance();

        // LS write yields no response; following IF read routes normally
        ls_vld[1] = 1; ls_wen[1] = 1; ls_ben[1] = 4'b0011; ls_wdt[1] = 32'hDEADBEEF;
        ls_adr[1] = 32'h800; m_rdt[1] = 32'h55;
        sample();
        chk("t6_m_ctl", 1, {m_vld[1], m_wen[1], m_ben[1]}, {1'b1, 1'b1, 4'b0011});
        chk("t6_m_wdt", 1, m_wdt[1], 32'hDEADBEEF);
        chk("t6_ls_rdy", 1, ls_rdy[1], 1);
        advance();
        ls_vld[1] = 0; ls_wen[1] = 0; if_vld[1] = 1; if_adr[1] = 32'h900; m_rdt[1] = 32'h77;
        sample(); chk("t6_ls_rdt", 1, ls_rdt[1], 32'hB1); chk("t6_if_rdt", 1, if_rdt[1], 32'hA2); advance();
        if_vld[1] = 0; m_rdt[1] = 32'h99;
        sample(); chk("t6_if_rdt", 1, if_rdt[1], 32'h99); chk("t6_ls_rdt", 1, ls_rdt[1], 32'hB1); advance();

        // Asynchronous reset in the middle of a locked transfer
        for (int k = 0; k < 2; k++) begin
            if_vld[k] = 1; if_adr[k] = 32'hA00; m_rdy[k] = 0; m_rdt[k] = 32'h5A;
        end
        sample(); advance();
        sample();
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_mid_rdy", k, {if_rdy[k], ls_rdy[k]}, 0);
            chk("rst_mid_rdt", k, {if_rdt[k], ls_rdt[k]}, 0);
        end
        mdl_reset();
        advance();
        idle(0); idle(1);
        sample(); advance();
        rst = 1'b0;

        // Randomized traffic on both instances
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!(if_vld[k] && !(s_hs[k] && s_g[k] == 1))) begin
                    if_vld[k] = ($urandom_range(0, 99) < 60);
                    if_adr[k] = $urandom & 32'hFFFF_FFFC;
                end
                if (!(ls_vld[k] && !(s_hs[k] && s_g[k] == 2))) begin
                    ls_vld[k] = ($urandom_range(0, 99) < 60);
                    ls_wen[k] = $urandom_range(0, 1) == 1;
                    ls_adr[k] = $urandom;
                    ls_ben[k] = 4'($urandom);
                    ls_wdt[k] = $urandom;
                end
                m_rdy[k] = ($urandom_range(0, 99) < 70);
                m_rdt[k] = $urandom;
            end
            sample();
            advance();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
